// File: rtl/data_memory_responder.sv
// data_memory_responder
//   Multi-cycle data memory for the MEM stage. It accepts one load or store at
//   a time, counts out a fixed access latency and then returns a one-cycle ack.
//   While an access is in flight, stall_o freezes the upstream pipeline.
//   A store is committed to the array only on the edge that raises ack_o.
//
// Ports
//   clk_i       clock, rising edge
//   rst_i       asynchronous, active-high reset (the array is not reset)
//   addr_i      byte address; word index = addr_i[DEPTH_LOG2+1:2]
//   wdata_i     store data
//   MemRead_i   load request
//   MemWrite_i  store request (wins when both requests are high)
//   rdata_o     load data, valid while ack_o=1, held afterwards
//   ack_o       one-cycle completion pulse
//   stall_o     combinational pipeline freeze, req & ~ack_o
//   busy_o      FSM is not idle
//
// state | meaning
// IDLE  | waiting for a request; a request is latched on the next edge
// BUSY  | access in flight, cnt counts down to the completion edge
// DONE  | ack cycle; always returns to IDLE next edge
module data_memory_responder #(
  parameter int LATENCY    = 4,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        stall_o,
  output logic        busy_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  // BUSY is entered with LATENCY-2 so that DONE lands exactly LATENCY edges
  // after acceptance.
  localparam logic [3:0] CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [31:0]           wdata_q;
  logic                  write_q;
  logic [31:0]           mem [DEPTH];

  logic                  req;
  logic                  accept;
  logic                  finish;
  logic [DEPTH_LOG2-1:0] idx_sel;
  logic [31:0]           wdata_sel;
  logic                  write_sel;
  logic                  unused_addr;

  assign req = MemRead_i | MemWrite_i;

  // With LATENCY=1 the access completes on its acceptance edge, so the live
  // request is used in IDLE; otherwise the latched copy is authoritative.
  assign idx_sel   = (state_q == S_IDLE) ? addr_i[DEPTH_LOG2+1:2] : idx_q;
  assign wdata_sel = (state_q == S_IDLE) ? wdata_i : wdata_q;
  assign write_sel = (state_q == S_IDLE) ? MemWrite_i : write_q;

  assign unused_addr = ^{addr_i[31:DEPTH_LOG2+2], addr_i[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_d = S_DONE;
            finish  = 1'b1;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        // A dropped request mid-access is abandoned without write or ack.
        if (!req) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = S_DONE;
          finish  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      ack_o   <= 1'b0;
      rdata_o <= 32'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_o   <= finish;
      if (accept) begin
        idx_q   <= addr_i[DEPTH_LOG2+1:2];
        wdata_q <= wdata_i;
        write_q <= MemWrite_i;
      end
      if (finish) begin
        rdata_o <= write_sel ? 32'd0 : mem[idx_sel];
      end
    end
  end

  // The array keeps its contents across reset; the rst_i gate keeps a
  // LATENCY=1 request presented during reset from writing.
  always_ff @(posedge clk_i) begin
    if (finish && write_sel && !rst_i) begin
      mem[idx_sel] <= wdata_sel;
    end
  end

  assign stall_o = req & ~ack_o;
  assign busy_o  = (state_q != S_IDLE);

endmodule
